// File: rtl/leaf_stream_packetizer.sv
// Transmit-side BFT packetizer: round-robin arbitration over user ap_vld/ap_ack streams,
// with per-port credit tracking so remote leaf input BRAMs are never overrun.
module leaf_stream_packetizer #(
   parameter int PACKET_BITS           = 49,
   parameter int PAYLOAD_BITS          = 32,
   parameter int NUM_LEAF_BITS         = 5,
   parameter int NUM_PORT_BITS         = 4,
   parameter int NUM_ADDR_BITS         = 7,
   parameter int NUM_OUT_PORTS         = 2,
   parameter int FREESPACE_UPDATE_SIZE = 64,
   parameter int CREDIT_INIT           = 128
) (
   input  logic                                    clk_bft,
   input  logic                                    reset,
   input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_leaf_user2interface,
   input  logic [NUM_OUT_PORTS-1:0]                vld_user2interface,
   output logic [NUM_OUT_PORTS-1:0]                ack_interface2user,
   input  logic [NUM_OUT_PORTS*NUM_LEAF_BITS-1:0]  dest_leaf_cfg,
   input  logic [NUM_OUT_PORTS*NUM_PORT_BITS-1:0]  dest_port_cfg,
   input  logic                                    credit_update_vld,
   input  logic [NUM_PORT_BITS-1:0]                credit_update_port,
   output logic [PACKET_BITS-1:0]                  dout_leaf_interface2bft,
   input  logic                                    bft_ready
);

   localparam int PTR_BITS    = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
   localparam int CREDIT_BITS = $clog2(CREDIT_INIT + 1);

   logic [CREDIT_BITS-1:0]   credit      [NUM_OUT_PORTS];
   logic [CREDIT_BITS-1:0]   credit_next [NUM_OUT_PORTS];
   logic [NUM_ADDR_BITS-1:0] seq         [NUM_OUT_PORTS];
   logic [PTR_BITS-1:0]      rr_ptr;
   logic [NUM_OUT_PORTS-1:0] eligible;
   logic                     out_valid;
   logic                     out_free;
   logic                     grant_vld;
   logic [PTR_BITS-1:0]      grant_idx;
   logic [PACKET_BITS-1:0]   grant_pkt;
   int                       search_idx;
   int                       credit_sum;

   assign out_valid = dout_leaf_interface2bft[PACKET_BITS-1];
   assign out_free  = !out_valid || bft_ready;

   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
         eligible[i] = vld_user2interface[i] && (credit[i] != '0);
      end
   end

   // Circular search starting at rr_ptr; reset suppresses grants so ack stays low while held.
   always_comb begin
      grant_vld  = 1'b0;
      grant_idx  = '0;
      search_idx = 0;
      for (int k = 0; k < NUM_OUT_PORTS; k++) begin
         search_idx = int'(rr_ptr) + k;
         if (search_idx >= NUM_OUT_PORTS) begin
            search_idx = search_idx - NUM_OUT_PORTS;
         end
         if (!grant_vld && out_free && !reset && eligible[search_idx]) begin
            grant_vld = 1'b1;
            grant_idx = PTR_BITS'(search_idx);
         end
      end
   end

   always_comb begin
      ack_interface2user = '0;
      grant_pkt          = '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
         if (grant_vld && int'(grant_idx) == i) begin
            ack_interface2user[i] = 1'b1;
            grant_pkt = {1'b1,
                         dest_leaf_cfg[i*NUM_LEAF_BITS +: NUM_LEAF_BITS],
                         dest_port_cfg[i*NUM_PORT_BITS +: NUM_PORT_BITS],
                         seq[i],
                         din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS]};
         end
      end
   end

   // Update and grant may hit the same port in one cycle; saturate after combining both.
   always_comb begin
      credit_sum = 0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
         credit_sum = int'(credit[i]);
         if (credit_update_vld && int'(credit_update_port) == i) begin
            credit_sum = credit_sum + FREESPACE_UPDATE_SIZE;
         end
         if (grant_vld && int'(grant_idx) == i) begin
            credit_sum = credit_sum - 1;
         end
         if (credit_sum > CREDIT_INIT) begin
            credit_sum = CREDIT_INIT;
         end
         credit_next[i] = CREDIT_BITS'(credit_sum);
      end
   end

   always_ff @(posedge clk_bft or posedge reset) begin
      if (reset) begin
         dout_leaf_interface2bft <= '0;
         rr_ptr                  <= '0;
         for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            credit[i] <= CREDIT_BITS'(CREDIT_INIT);
            seq[i]    <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            credit[i] <= credit_next[i];
            if (grant_vld && int'(grant_idx) == i) begin
               seq[i] <= seq[i] + NUM_ADDR_BITS'(1);
            end
         end
         if (grant_vld) begin
            dout_leaf_interface2bft <= grant_pkt;
            rr_ptr <= (int'(grant_idx) == NUM_OUT_PORTS - 1) ? '0 : grant_idx + PTR_BITS'(1);
         end else if (bft_ready) begin
            dout_leaf_interface2bft <= '0;
         end
      end
   end

endmodule

// File: tb/tb_leaf_stream_packetizer.sv
// Directed bench for leaf_stream_packetizer: arbitration, packet format, backpressure,
// credit exhaustion/refill/saturation and asynchronous reset.
module tb_leaf_stream_packetizer;

   logic        clk_bft = 1'b0;
   logic        reset;
   logic [63:0] din;
   logic [1:0]  vld;
   logic [1:0]  ack;
   logic [9:0]  dest_leaf_cfg;
   logic [7:0]  dest_port_cfg;
   logic        credit_update_vld;
   logic [3:0]  credit_update_port;
   logic [48:0] dout;
   logic        bft_ready;

   int          testsRun = 0;
   int          testsFailed = 0;
   logic [6:0]  seqModel0;
   int          wordCnt;
   int          n;
   logic [48:0] prevPkt;

   always #5 clk_bft = ~clk_bft;

   assign dest_leaf_cfg = {5'd17, 5'd5};
   assign dest_port_cfg = {4'd9, 4'd2};

   leaf_stream_packetizer dut (
      .clk_bft                 (clk_bft),
      .reset                   (reset),
      .din_leaf_user2interface (din),
      .vld_user2interface      (vld),
      .ack_interface2user      (ack),
      .dest_leaf_cfg           (dest_leaf_cfg),
      .dest_port_cfg           (dest_port_cfg),
      .credit_update_vld       (credit_update_vld),
      .credit_update_port      (credit_update_port),
      .dout_leaf_interface2bft (dout),
      .bft_ready               (bft_ready)
   );

   function automatic logic [48:0] makePkt(input logic [4:0] leaf, input logic [3:0] port,
                                           input logic [6:0] seq, input logic [31:0] data);
      return {1'b1, leaf, port, seq, data};
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                                input logic r);
      @(posedge clk_bft);
      #1;
      vld       = v;
      din       = {d1, d0};
      bft_ready = r;
   endtask

   task automatic pulseUpdate(input logic [3:0] port);
      @(posedge clk_bft);
      #1;
      credit_update_vld  = 1'b1;
      credit_update_port = port;
      @(posedge clk_bft);
      #1;
      credit_update_vld  = 1'b0;
   endtask

   // Streams words on port 0 until it stops being acked or the cycle budget runs out.
   task automatic drainPort0(input int maxCycles, input logic withUpdate, output int acks);
      logic        havePend;
      logic [48:0] expPkt;
      havePend = 1'b0;
      expPkt   = '0;
      acks     = 0;
      @(posedge clk_bft);
      #1;
      vld                = 2'b01;
      din[31:0]          = wordCnt[31:0];
      credit_update_vld  = withUpdate;
      credit_update_port = 4'd0;
      for (int c = 0; c < maxCycles; c++) begin
         @(negedge clk_bft);
         if (havePend) begin
            checkOutput("drain_pkt", 64'(dout), 64'(expPkt));
            havePend = 1'b0;
         end
         if (ack !== 2'b01) break;
         expPkt = makePkt(5'd5, 4'd2, seqModel0, din[31:0]);
         seqModel0++;
         acks++;
         havePend = 1'b1;
         @(posedge clk_bft);
         #1;
         credit_update_vld = 1'b0;
         wordCnt++;
         din[31:0] = wordCnt[31:0];
      end
      credit_update_vld = 1'b0;
      vld = 2'b00;
      if (havePend) begin
         @(negedge clk_bft);
         checkOutput("drain_last_pkt", 64'(dout), 64'(expPkt));
      end
   endtask

   initial begin
      reset              = 1'b1;
      vld                = 2'b00;
      din                = '0;
      bft_ready          = 1'b0;
      credit_update_vld  = 1'b0;
      credit_update_port = '0;
      seqModel0          = '0;
      wordCnt            = 0;
      prevPkt            = '0;

      repeat (2) @(posedge clk_bft);
      @(negedge clk_bft);
      checkOutput("reset_dout", 64'(dout), 64'd0);
      checkOutput("reset_ack", 64'(ack), 64'd0);
      @(posedge clk_bft);
      #1;
      reset = 1'b0;

      // single word on port 0
      applyStimulus(2'b01, 32'hDEADBEEF, 32'h0, 1'b1);
      @(negedge clk_bft);
      checkOutput("single_ack", 64'(ack), 64'd1);
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b1);
      @(negedge clk_bft);
      checkOutput("single_pkt", 64'(dout), 64'(makePkt(5'd5, 4'd2, 7'd0, 32'hDEADBEEF)));
      checkOutput("single_ack_drop", 64'(ack), 64'd0);
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b1);
      @(negedge clk_bft);
      checkOutput("single_clear", 64'(dout), 64'd0);

      // both ports valid: rr_ptr now points at port 1, so grants go 1,0,1,0,1,0
      for (int c = 0; c < 6; c++) begin
         applyStimulus(2'b11, 32'hA000_0000 + 32'(c), 32'hB000_0000 + 32'(c), 1'b1);
         @(negedge clk_bft);
         if (c > 0) checkOutput("rr_pkt", 64'(dout), 64'(prevPkt));
         if (c % 2 == 0) begin
            checkOutput("rr_ack_p1", 64'(ack), 64'd2);
            prevPkt = makePkt(5'd17, 4'd9, 7'(c / 2), 32'hB000_0000 + 32'(c));
         end else begin
            checkOutput("rr_ack_p0", 64'(ack), 64'd1);
            prevPkt = makePkt(5'd5, 4'd2, 7'(1 + c / 2), 32'hA000_0000 + 32'(c));
         end
      end
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b1);
      @(negedge clk_bft);
      checkOutput("rr_last_pkt", 64'(dout), 64'(prevPkt));

      // backpressure: packet held for 5 cycles with no acks
      applyStimulus(2'b01, 32'h1111_1111, 32'h0, 1'b1);
      @(negedge clk_bft);
      checkOutput("bp_first_ack", 64'(ack), 64'd1);
      prevPkt = makePkt(5'd5, 4'd2, 7'd4, 32'h1111_1111);
      for (int c = 0; c < 5; c++) begin
         applyStimulus(2'b01, 32'h2222_2222, 32'h0, 1'b0);
         @(negedge clk_bft);
         checkOutput("bp_hold_dout", 64'(dout), 64'(prevPkt));
         checkOutput("bp_hold_ack", 64'(ack), 64'd0);
      end
      applyStimulus(2'b01, 32'h2222_2222, 32'h0, 1'b1);
      @(negedge clk_bft);
      checkOutput("bp_release_ack", 64'(ack), 64'd1);
      checkOutput("bp_release_dout", 64'(dout), 64'(prevPkt));
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b1);
      @(negedge clk_bft);
      checkOutput("bp_next_pkt", 64'(dout), 64'(makePkt(5'd5, 4'd2, 7'd5, 32'h2222_2222)));

      // asynchronous reset while a packet is stalled
      applyStimulus(2'b10, 32'h0, 32'hCAFE_F00D, 1'b0);
      @(negedge clk_bft);
      checkOutput("pre_reset_ack", 64'(ack), 64'd2);
      applyStimulus(2'b01, 32'h0, 32'hCAFE_F00D, 1'b0);
      @(negedge clk_bft);
      checkOutput("pre_reset_pkt", 64'(dout), 64'(makePkt(5'd17, 4'd9, 7'd3, 32'hCAFE_F00D)));
      checkOutput("pre_reset_stall_ack", 64'(ack), 64'd0);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("async_reset_dout", 64'(dout), 64'd0);
      checkOutput("async_reset_ack", 64'(ack), 64'd0);
      @(posedge clk_bft);
      #1;
      reset     = 1'b0;
      vld       = 2'b00;
      bft_ready = 1'b1;
      seqModel0 = '0;
      wordCnt   = 0;

      // credit exhaustion: exactly 128 words from a fresh reset
      drainPort0(140, 1'b0, n);
      checkOutput("exhaust_count", 64'(n), 64'd128);
      @(posedge clk_bft);
      #1;
      vld                = 2'b01;
      credit_update_vld  = 1'b1;
      credit_update_port = 4'd0;
      @(negedge clk_bft);
      checkOutput("zero_credit_no_ack", 64'(ack), 64'd0);
      @(posedge clk_bft);
      #1;
      credit_update_vld = 1'b0;
      vld = 2'b00;
      drainPort0(100, 1'b0, n);
      checkOutput("refill_count", 64'(n), 64'd64);

      // out-of-range update port is ignored
      @(posedge clk_bft);
      #1;
      vld                = 2'b01;
      credit_update_vld  = 1'b1;
      credit_update_port = 4'd9;
      @(negedge clk_bft);
      checkOutput("port9_same_cycle", 64'(ack), 64'd0);
      @(posedge clk_bft);
      #1;
      credit_update_vld = 1'b0;
      @(negedge clk_bft);
      checkOutput("port9_ignored", 64'(ack), 64'd0);
      vld = 2'b00;

      // update coinciding with a grant at credit 10: one grant plus 73 more
      pulseUpdate(4'd0);
      drainPort0(54, 1'b0, n);
      checkOutput("consume_to_10", 64'(n), 64'd54);
      drainPort0(200, 1'b1, n);
      checkOutput("update_with_grant", 64'(n), 64'd74);

      // saturation: three updates from zero cap at 128
      pulseUpdate(4'd0);
      pulseUpdate(4'd0);
      pulseUpdate(4'd0);
      drainPort0(200, 1'b0, n);
      checkOutput("saturate_count", 64'(n), 64'd128);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/leaf_stream_packetizer.md
Name: leaf_stream_packetizer

Overview:
Transmit-side packetizer between user-operator output streams and the BFT network. It takes up to NUM_OUT_PORTS ap_vld/ap_ack user streams and round-robin arbitrates among them. Each accepted word is wrapped into a BFT packet carrying destination leaf, destination port and per-stream sequence address. Per-port credit counters track receiver freespace, so the block never overruns a remote leaf's input BRAM.

Parameters:
PACKET_BITS, 49, BFT packet width; must equal 1+NUM_LEAF_BITS+NUM_PORT_BITS+NUM_ADDR_BITS+PAYLOAD_BITS
PAYLOAD_BITS, 32, user data width
NUM_LEAF_BITS, 5, destination leaf field width
NUM_PORT_BITS, 4, destination port field width
NUM_ADDR_BITS, 7, sequence-address field width
NUM_OUT_PORTS, 2, number of user output streams
FREESPACE_UPDATE_SIZE, 64, credits added per credit update
CREDIT_INIT, 128, per-port credits after reset (equals receiver BRAM depth)

Ports:
clk_bft  in  1  sole clock
reset  in  1  asynchronous, active-high reset
din_leaf_user2interface  in  NUM_OUT_PORTS*PAYLOAD_BITS  user words; port i at slice [i*PAYLOAD_BITS +: PAYLOAD_BITS]
vld_user2interface  in  NUM_OUT_PORTS  per-port word valid (ap_vld)
ack_interface2user  out  NUM_OUT_PORTS  per-port accept (ap_ack), combinational
dest_leaf_cfg  in  NUM_OUT_PORTS*NUM_LEAF_BITS  static destination leaf per port
dest_port_cfg  in  NUM_OUT_PORTS*NUM_PORT_BITS  static destination port per port
credit_update_vld  in  1  one-cycle freespace return pulse
credit_update_port  in  NUM_PORT_BITS  local port index receiving the credits
dout_leaf_interface2bft  out  PACKET_BITS  packet to BFT; bit [PACKET_BITS-1] is the valid flag
bft_ready  in  1  BFT accepts the packet this cycle

Behaviour:
- Reset state:
  - dout_leaf_interface2bft = 0.
  - ack_interface2user = 0.
  - credit[i] = CREDIT_INIT.
  - seq[i] = 0.
  - rr_ptr = 0.
- Packet format: {1'b1, dest_leaf[i], dest_port[i], seq[i], payload}, MSB first.
- out_free = !out_valid || bft_ready.
- Port i is eligible when vld[i] && credit[i] != 0.
- Grant: when out_free, the first eligible port searching circularly from rr_ptr wins. At most one grant per cycle.
- ack_interface2user[granted] = 1 in that same cycle; every other ack = 0. ack is never asserted while out_free = 0.
- On the edge after a grant:
  - the output register loads the packet (latency 1 cycle from grant);
  - seq[i] increments modulo 2^NUM_ADDR_BITS (127 wraps to 0);
  - credit[i] decrements by 1;
  - rr_ptr = granted+1, wrapping from NUM_OUT_PORTS-1 to 0.
- rr_ptr is unchanged in cycles with no grant.
- Output holding and clearing:
  - The output holds stable while out_valid && !bft_ready.
  - If bft_ready is high and no grant occurs, the output clears to 0 on the next edge.
  - Back-to-back packets run at 1 per cycle while bft_ready stays high.
- Credit updates:
  - A credit_update_vld pulse adds FREESPACE_UPDATE_SIZE to credit[credit_update_port].
  - If the same port is granted in the same cycle, the net change is +FREESPACE_UPDATE_SIZE-1.
  - Credits saturate at CREDIT_INIT.
  - credit_update_port >= NUM_OUT_PORTS is ignored.
  - Credit counter width is clog2(CREDIT_INIT+1).
- A port with credit = 0 is skipped and never acked. Its vld stays pending with no data loss.
- Reset asserted mid-transfer: all state clears immediately (asynchronous). Any in-flight output packet is dropped.

Test Plan:
- Reset, then single word: dest_leaf0=5, dest_port0=2, vld[0]=1 with 0xDEADBEEF, bft_ready=1 -> ack[0] high for 1 cycle; next cycle dout = {1, 5'd5, 4'd2, 7'd0, 32'hDEADBEEF}; credit[0]=127.
- Both ports hold vld continuously, bft_ready=1 -> grants alternate 0,1,0,1; each port's seq field reads 0,1,2…; one packet per cycle.
- Backpressure: bft_ready=0 for 5 cycles with a packet loaded -> dout stable, no acks. When bft_ready rises, the next packet follows in the next cycle.
- Credit exhaustion: 128 words on port 0 with no updates -> 129th word not acked. A credit_update (port 0) lets it proceed; credit[0] ends at 63. The seq field wrapped 127→0 at word 129.
- Credit update for port 0 in the same cycle as a grant of port 0 with credit 10 -> credit 73. An update on port index 9 -> no change. An update at credit 100 -> saturates at 128.
- Reset asserted while dout is valid and bft_ready=0 -> dout=0 and ack=0 immediately. After reset release the first packet has seq=0 and credits are 128.
